serial_pad_reader: RTL and testbench

- Console-side master for the latch/clock/data serial pad protocol, as used by NES and SNES controllers.
- On request it pulses latch, then issues BITS clock pulses. It samples the data line MSB first and presents the captured word in parallel.
- It polls physical pads and serves as the protocol master in benches that check the adapter's pad-emulation output path.

---
 rtl/serial_pad_reader.sv | 147 ++++++++++++++
 tb/tb_serial_pad_reader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_pad_reader.sv
// Console-side master for the latch/clock/data serial pad protocol
// (NES/SNES style). A start request produces one latch pulse followed by
// BITS clock pulses. The data line is sampled MSB first and the captured
// word is presented on buttons, together with a one-cycle valid pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; latch=0, clk=1, busy=0
// S_LATCH | latch held high for LATCH_CYCLES cycles; the pad loads its word
// S_GAP   | latch low, clk high for CLK_DIV cycles; the MSB settles
// S_LOW   | clk low for CLK_DIV cycles; data is sampled on the last cycle
// S_HIGH  | clk high for CLK_DIV cycles; the pad shifts to its next bit
module serial_pad_reader #(
   parameter int BITS         = 16,
   parameter int CLK_DIV      = 8,
   parameter int LATCH_CYCLES = 12
) (
   input  logic            system_clock,
   input  logic            reset,
   input  logic            start,
   input  logic            data,
   output logic            latch,
   output logic            clk,
   output logic            busy,
   output logic            valid,
   output logic [BITS-1:0] buttons
);

   localparam int MAXC  = (CLK_DIV > LATCH_CYCLES) ? CLK_DIV : LATCH_CYCLES;
   localparam int CNT_W = $clog2(MAXC);
   localparam int IDX_W = $clog2(BITS);

   localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_GAP,
      S_LOW,
      S_HIGH
   } state_t;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [IDX_W-1:0] r_idx;
   logic [BITS-1:0]  r_cap;
   logic             r_sync1;
   logic             r_sync2;
   logic             w_cnt_done;

   assign w_cnt_done = (r_cnt == '0);

   // The pad drives data from its own clock domain; two flops before use.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= data;
         r_sync2 <= r_sync1;
      end
   end

   // Sequencer: divider reloads on every state entry and counts down to zero.
   always_ff @(posedge system_clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_cap   <= '1;
         latch   <= 1'b0;
         clk     <= 1'b1;
         busy    <= 1'b0;
         valid   <= 1'b0;
         buttons <= '1;
      end else begin
         valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // A request coinciding with the completion pulse belongs to
               // the transaction that just ended and is dropped.
               if (start && !valid) begin
                  r_state <= S_LATCH;
                  r_cnt   <= LAT_LOAD;
                  latch   <= 1'b1;
                  busy    <= 1'b1;
               end
            end
            S_LATCH: begin
               if (w_cnt_done) begin
                  r_state <= S_GAP;
                  r_cnt   <= DIV_LOAD;
                  latch   <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_GAP: begin
               if (w_cnt_done) begin
                  r_state <= S_LOW;
                  r_cnt   <= DIV_LOAD;
                  r_idx   <= IDX_TOP;
                  clk     <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_LOW: begin
               if (w_cnt_done) begin
                  r_cap[r_idx] <= r_sync2;
                  r_state      <= S_HIGH;
                  r_cnt        <= DIV_LOAD;
                  clk          <= 1'b1;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            S_HIGH: begin
               if (w_cnt_done) begin
                  if (r_idx != '0) begin
                     r_idx   <= r_idx - 1'b1;
                     r_state <= S_LOW;
                     r_cnt   <= DIV_LOAD;
                     clk     <= 1'b0;
                  end else begin
                     buttons <= r_cap;
                     valid   <= 1'b1;
                     busy    <= 1'b0;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
               latch   <= 1'b0;
               clk     <= 1'b1;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_pad_reader.sv
// Bench for serial_pad_reader: a default-parameter instance and an 8-bit
// instance, each driven by a behavioural pad that loads on latch and shifts
// MSB first on rising clk.
module tb_serial_pad_reader;

   logic system_clock = 1'b0;
   logic reset        = 1'b1;
   logic start_r      = 1'b0;
   logic sel          = 1'b0;

   logic        st16, data16, latch16, clk16, busy16, valid16;
   logic [15:0] buttons16;
   logic        st8, data8, latch8, clk8, busy8, valid8;
   logic [7:0]  buttons8;

   logic        m_latch, m_clk, m_busy, m_valid;

   logic [15:0] pad_word  = 16'h0000;
   logic [7:0]  pad8_word = 8'h00;
   int          pad_mode  = 0;
   logic        pad_dly   = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 system_clock = ~system_clock;

   assign st16    = start_r & ~sel;
   assign st8     = start_r & sel;
   assign m_latch = sel ? latch8 : latch16;
   assign m_clk   = sel ? clk8   : clk16;
   assign m_busy  = sel ? busy8  : busy16;
   assign m_valid = sel ? valid8 : valid16;

   serial_pad_reader dut (
      .system_clock(system_clock), .reset(reset), .start(st16), .data(data16),
      .latch(latch16), .clk(clk16), .busy(busy16), .valid(valid16),
      .buttons(buttons16)
   );

   serial_pad_reader #(.BITS(8), .CLK_DIV(6), .LATCH_CYCLES(4)) dut8 (
      .system_clock(system_clock), .reset(reset), .start(st8), .data(data8),
      .latch(latch8), .clk(clk8), .busy(busy8), .valid(valid8),
      .buttons(buttons8)
   );

   // 16-bit pad: optional 3-cycle output delay, or tied high/low
   logic [15:0] sh16 = 16'h0;
   logic [2:0]  dly16 = 3'b0;
   logic        pc16 = 1'b1;
   always @(posedge system_clock) begin
      pc16 <= clk16;
      if (latch16) sh16 <= pad_word;
      else if (clk16 && !pc16) sh16 <= {sh16[14:0], 1'b0};
      dly16 <= {dly16[1:0], sh16[15]};
   end
   assign data16 = (pad_mode == 1) ? 1'b1 :
                   (pad_mode == 2) ? 1'b0 :
                   (pad_dly ? dly16[2] : sh16[15]);

   // 8-bit pad
   logic [7:0] sh8 = 8'h0;
   logic       pc8 = 1'b1;
   always @(posedge system_clock) begin
      pc8 <= clk8;
      if (latch8) sh8 <= pad8_word;
      else if (clk8 && !pc8) sh8 <= {sh8[6:0], 1'b0};
   end
   assign data8 = sh8[7];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One start at cycle 0, then observe for win cycles.
   // extra: cycle of an additional start (-1 none); b2b: start at valid
   // cycle + b2b (-1 none); rst_at: cycle at which reset is pulsed (-1 none).
   task automatic run_txn(input int win, input int extra, input int b2b, input int rst_at,
                          output int lat, output int lat2, output int falls,
                          output int lhi, output int nval, output logic b1);
      logic pc;
      pc = m_clk; lat = -1; lat2 = -1; falls = 0; lhi = 0; nval = 0; b1 = 1'b0;
      @(negedge system_clock);
      start_r = 1'b1;
      for (int n = 1; n <= win; n++) begin
         @(negedge system_clock);
         if (n == 1) b1 = m_busy;
         if (m_clk == 1'b0 && pc == 1'b1) falls++;
         pc = m_clk;
         if (m_latch) lhi++;
         if (m_valid) begin
            nval++;
            if (lat < 0) lat = n;
            else if (lat2 < 0) lat2 = n;
         end
         start_r = (n == extra) || (b2b >= 0 && lat >= 0 && n == lat + b2b);
         if (n == rst_at) begin
            reset = 1'b1;
            #1;
            chk("rst_latch", {31'b0, m_latch}, 32'd0);
            chk("rst_clk",   {31'b0, m_clk},   32'd1);
            chk("rst_busy",  {31'b0, m_busy},  32'd0);
            pc = m_clk;
         end
         if (rst_at >= 0 && n == rst_at + 2) reset = 1'b0;
      end
      start_r = 1'b0;
   endtask

   int lat, lat2, falls, lhi, nval;
   logic b1;

   initial begin
      repeat (3) @(negedge system_clock);
      chk("init_latch",   {31'b0, latch16}, 32'd0);
      chk("init_clk",     {31'b0, clk16},   32'd1);
      chk("init_busy",    {31'b0, busy16},  32'd0);
      chk("init_valid",   {31'b0, valid16}, 32'd0);
      chk("init_buttons", {16'b0, buttons16}, 32'h0000FFFF);
      chk("init_buttons8", {24'b0, buttons8}, 32'h000000FF);
      reset = 1'b0;
      repeat (2) @(negedge system_clock);

      // basic loopback
      pad_word = 16'hA5C3;
      run_txn(300, -1, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("a5c3_lat",   lat,   32'd277);
      chk("a5c3_falls", falls, 32'd16);
      chk("a5c3_latch", lhi,   32'd12);
      chk("a5c3_nval",  nval,  32'd1);
      chk("a5c3_busy1", {31'b0, b1}, 32'd1);
      chk("a5c3_btn",   {16'b0, buttons16}, 32'h0000A5C3);
      chk("a5c3_idle",  {31'b0, busy16}, 32'd0);

      pad_mode = 1;
      run_txn(300, -1, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("high_btn",  {16'b0, buttons16}, 32'h0000FFFF);
      chk("high_nval", nval, 32'd1);
      pad_mode = 2;
      run_txn(300, -1, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("low_btn",  {16'b0, buttons16}, 32'h00000000);
      chk("low_nval", nval, 32'd1);
      pad_mode = 0;

      // start while busy is dropped
      pad_word = 16'h1234;
      run_txn(320, 50, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("busy_start_nval",  nval,  32'd1);
      chk("busy_start_falls", falls, 32'd16);
      chk("busy_start_btn",   {16'b0, buttons16}, 32'h00001234);

      // start in the valid cycle is dropped
      pad_word = 16'h0F0F;
      run_txn(600, -1, 0, -1, lat, lat2, falls, lhi, nval, b1);
      chk("same_cyc_nval",  nval,  32'd1);
      chk("same_cyc_falls", falls, 32'd16);

      // start one cycle after valid runs a full second transaction
      pad_word = 16'hC3A5;
      run_txn(600, -1, 1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("b2b_nval",  nval,  32'd2);
      chk("b2b_lat1",  lat,   32'd277);
      chk("b2b_lat2",  lat2 - lat - 1, 32'd277);
      chk("b2b_falls", falls, 32'd32);
      chk("b2b_btn",   {16'b0, buttons16}, 32'h0000C3A5);

      // reset mid-transaction
      pad_word = 16'hA5C3;
      run_txn(400, -1, -1, 100, lat, lat2, falls, lhi, nval, b1);
      chk("rst_nval",    nval, 32'd0);
      chk("rst_buttons", {16'b0, buttons16}, 32'h0000FFFF);
      chk("rst_idle",    {31'b0, busy16}, 32'd0);

      // 8-bit instance
      sel = 1'b1;
      pad8_word = 8'h5A;
      run_txn(150, -1, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("b8_lat",   lat,   32'd107);
      chk("b8_falls", falls, 32'd8);
      chk("b8_latch", lhi,   32'd4);
      chk("b8_btn",   {24'b0, buttons8}, 32'h0000005A);
      sel = 1'b0;

      // pad output lags clk rise by 3 cycles
      pad_dly  = 1'b1;
      pad_word = 16'h5555;
      run_txn(300, -1, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("dly_btn_5555", {16'b0, buttons16}, 32'h00005555);
      chk("dly_lat",      lat, 32'd277);
      pad_word = 16'hAAAA;
      run_txn(300, -1, -1, -1, lat, lat2, falls, lhi, nval, b1);
      chk("dly_btn_aaaa", {16'b0, buttons16}, 32'h0000AAAA);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
